// File: rtl/coef_reload_ctrl_pkg.sv
// rtl/coef_reload_ctrl_pkg.sv - shared types and helpers for the coefficient reload controller
// Package fir_ctrl_pkg:
//   state_t   : reload FSM state encoding (IDLE, LOAD, SWAP, ERR)
//   cnt_width : tap counter width for a given tap count (never below 1 bit)
package fir_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SWAP = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  function automatic int cnt_width(input int taps);
    return (taps <= 2) ? 1 : $clog2(taps);
  endfunction

endpackage

// File: rtl/coef_reload_ctrl_if.sv
// rtl/coef_reload_ctrl_if.sv - coefficient input stream interface
// Signals:
//   s_data  : coefficient word (WIDTH bits)
//   s_valid : s_data is valid
//   s_last  : marks the final coefficient of a reload
//   s_ready : consumer accepts a word
// Modports: master (coefficient source), slave (reload controller)
interface coef_reload_ctrl_if #(
  parameter int WIDTH = 16
);

  logic [WIDTH-1:0] s_data;
  logic             s_valid;
  logic             s_last;
  logic             s_ready;

  modport master (output s_data, output s_valid, output s_last, input s_ready);
  modport slave  (input s_data, input s_valid, input s_last, output s_ready);

endinterface

// File: rtl/coef_reload_ctrl_tap_counter.sv
// rtl/coef_reload_ctrl_tap_counter.sv - saturating tap counter with terminal-count flag
// Module tap_counter
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear to 0 (has priority over inc)
//   inc        : count one accepted word
//   tc         : count has reached TAPS-1
module tap_counter
  import fir_ctrl_pkg::*;
#(
  parameter int TAPS = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam int CW = cnt_width(TAPS);
  localparam logic [CW-1:0] LAST = CW'(TAPS - 1);

  logic [CW-1:0] count;

  assign tc = (count == LAST);

  // Saturates at TAPS-1: the word that hits terminal count ends the reload,
  // so the counter must not wrap and alias the next load's first word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !tc) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/coef_reload_ctrl.sv
// rtl/coef_reload_ctrl.sv - streams TAPS coefficients into a shadow chain, then commits them
// Optional feature macro: COEF_LAST_CHECK_EN (s_last framing check, ERR state reachable)
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   load_start  : single-cycle request to begin a reload (honoured in IDLE/ERR)
//   s           : coefficient input stream (slave side)
//   chain_data  : word presented to the shadow shift chain (holds last value)
//   chain_shift : shift-enable pulse, one cycle after each accepted word
//   swap        : single-cycle commit of shadow chain to active bank
//   busy        : high in LOAD or SWAP
//   done        : single-cycle pulse on successful reload
//   err         : sticky framing-error flag, cleared by load_start
module coef_reload_ctrl
  import fir_ctrl_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int TAPS  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_start,
  coef_reload_ctrl_if.slave s,
  output logic [WIDTH-1:0] chain_data,
  output logic             chain_shift,
  output logic             swap,
  output logic             busy,
  output logic             done,
  output logic             err
);

  generate
    if (TAPS < 2) begin : g_bad_taps
      $error("coef_reload_ctrl: TAPS must be 2 or more");
    end
  endgenerate

  state_t state;
  logic   accept;
  logic   start;
  logic   tc;
  logic   frame_bad;

  assign s.s_ready = (state == ST_LOAD);
  assign busy      = (state == ST_LOAD) || (state == ST_SWAP);
  assign accept    = s.s_valid && s.s_ready;
  assign start     = load_start && ((state == ST_IDLE) || (state == ST_ERR));

`ifdef COEF_LAST_CHECK_EN
  // s_last must coincide exactly with the terminal-count word.
  assign frame_bad = (s.s_last != tc);
`else
  // s_last is deliberately ignored in this build.
  assign frame_bad = 1'b0 & s.s_last;
`endif

  tap_counter #(
    .TAPS (TAPS)
  ) u_tap_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start),
    .inc   (accept),
    .tc    (tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      chain_data  <= '0;
      chain_shift <= 1'b0;
      swap        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      // The shift pulse follows every accepted word, including an offending
      // one, so the shadow chain always mirrors what was consumed.
      chain_shift <= accept;
      if (accept) begin
        chain_data <= s.s_data;
      end
      swap <= 1'b0;
      done <= 1'b0;

      case (state)
        ST_IDLE, ST_ERR: begin
          if (load_start) begin
            state <= ST_LOAD;
            err   <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            if (frame_bad) begin
              state <= ST_ERR;
              err   <= 1'b1;
            end else if (tc) begin
              state <= ST_SWAP;
            end
          end
        end
        ST_SWAP: begin
          // First SWAP cycle waits out the final chain_shift; the second
          // issues swap; done follows as the FSM returns to IDLE.
          if (!swap) begin
            swap <= 1'b1;
          end else begin
            done  <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_coef_reload_ctrl.sv
// tb/tb_coef_reload_ctrl.sv - directed self-checking bench for coef_reload_ctrl (WIDTH=16, TAPS=4)
module tb_coef_reload_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_start = 1'b0;
  logic [15:0] chain_data;
  logic        chain_shift;
  logic        swap;
  logic        busy;
  logic        done;
  logic        err;

  coef_reload_ctrl_if #(.WIDTH(16)) cif ();

  coef_reload_ctrl #(
    .WIDTH (16),
    .TAPS  (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_start  (load_start),
    .s           (cif),
    .chain_data  (chain_data),
    .chain_shift (chain_shift),
    .swap        (swap),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] shift_q[$];
  int swap_cnt = 0;
  int done_cnt = 0;
  int swap_cyc = -100;
  int done_cyc = -100;
  int last_shift_cyc = -100;
  int acc_cyc = -100;

  always @(negedge clk) begin
    if (chain_shift) begin
      shift_q.push_back(chain_data);
      last_shift_cyc = cyc;
    end
    if (swap) begin
      swap_cnt++;
      swap_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    shift_q.delete();
    swap_cnt = 0;
    done_cnt = 0;
    swap_cyc = -100;
    done_cyc = -100;
    last_shift_cyc = -100;
    acc_cyc = -100;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  // Entered and left on a falling edge; returns on the falling edge right
  // after the accepting rising edge.
  task automatic send_word(input logic [15:0] d, input logic last, input int gap);
    int n;
    cif.s_valid = 1'b0;
    repeat (gap) @(negedge clk);
    cif.s_data  = d;
    cif.s_last  = last;
    cif.s_valid = 1'b1;
    n = 0;
    while (!cif.s_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    acc_cyc = cyc;
    cif.s_valid = 1'b0;
    cif.s_last  = 1'b0;
  endtask

  task automatic check_reload(input string tag);
    repeat (4) @(negedge clk);
    check({tag, "_nshift"}, shift_q.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < shift_q.size()) check({tag, "_data"}, shift_q[i], i + 1);
    end
    check({tag, "_swap_cnt"}, swap_cnt, 32'd1);
    check({tag, "_done_cnt"}, done_cnt, 32'd1);
    check({tag, "_swap_after_shift"}, swap_cyc - last_shift_cyc, 32'd1);
    check({tag, "_done_latency"}, done_cyc - acc_cyc, 32'd2);
    check({tag, "_busy_idle"}, busy, 1'b0);
    check({tag, "_err"}, err, 1'b0);
  endtask

  task automatic run_reload(input string tag, input int gap, input logic last_all);
    clear_mon();
    start_load();
    check({tag, "_busy_load"}, busy, 1'b1);
    for (int i = 0; i < 4; i++) begin
      send_word(16'(i + 1), last_all || (i == 3), gap);
    end
    check({tag, "_ready_drop"}, cif.s_ready, 1'b0);
    check({tag, "_busy_swap"}, busy, 1'b1);
    check_reload(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    cif.s_data  = '0;
    cif.s_valid = 1'b0;
    cif.s_last  = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", cif.s_ready, 1'b0);
    check("rst_chain_data", chain_data, 16'h0000);
    check("rst_shift", chain_shift, 1'b0);
    check("rst_swap", swap, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back reload
    run_reload("b2b", 0, 1'b0);

    // Reload with 2-cycle valid gaps
    run_reload("gap", 2, 1'b0);

    // Reset in the middle of a load
    clear_mon();
    start_load();
    send_word(16'h0001, 1'b0, 0);
    send_word(16'h0002, 1'b0, 0);
    rst_n = 1'b0;
    #1;
    check("midrst_shift", chain_shift, 1'b0);
    check("midrst_chain_data", chain_data, 16'h0000);
    check("midrst_ready", cif.s_ready, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_swap", swap, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_err", err, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("midrst_no_swap", swap_cnt, 32'd0);
    check("midrst_no_done", done_cnt, 32'd0);
    run_reload("after_rst", 0, 1'b0);

    // load_start during LOAD and during SWAP is ignored
    clear_mon();
    start_load();
    send_word(16'h0001, 1'b0, 0);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    send_word(16'h0002, 1'b0, 0);
    send_word(16'h0003, 1'b0, 0);
    send_word(16'h0004, 1'b1, 0);
    check("ign_ready_drop", cif.s_ready, 1'b0);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    check_reload("ign");

`ifdef COEF_LAST_CHECK_EN
    // Early s_last is a framing error
    clear_mon();
    start_load();
    send_word(16'h0001, 1'b0, 0);
    send_word(16'h0002, 1'b1, 0);
    check("ferr_err", err, 1'b1);
    check("ferr_ready", cif.s_ready, 1'b0);
    check("ferr_shift", chain_shift, 1'b1);
    check("ferr_data", chain_data, 16'h0002);
    repeat (3) @(negedge clk);
    check("ferr_no_swap", swap_cnt, 32'd0);
    check("ferr_no_done", done_cnt, 32'd0);
    check("ferr_sticky", err, 1'b1);
    run_reload("ferr_recover", 0, 1'b0);
`else
    // s_last ignored: asserted on every word
    run_reload("last_all", 0, 1'b1);
    check("last_all_err", err, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
